// File: rtl/serial_link_rx_pkg.sv
// Shared constants and types for the serial-link receive queue bridge.
package serial_link_rx_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // OBI register word indices (reader_addr_i[6:2])
  localparam logic [4:0] OFF_QUEUE0 = 5'd0;
  localparam logic [4:0] OFF_STATUS = 5'd16;
  localparam logic [4:0] OFF_FILL   = 5'd17;
  localparam logic [4:0] OFF_FLUSH  = 5'd21;
  localparam logic [4:0] OFF_IRQ_EN = 5'd22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/serial_link_rx_fifo.sv
// Single receive queue: power-of-two circular buffer with push, pop and flush.
module serial_link_rx_fifo #(
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DataWidth-1:0]     data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [DataWidth-1:0]     head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, waddr;
  logic [CntW-1:0]      count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A pop never sees a same-cycle push; flush overrides pop.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign waddr   = flush_i ? '0 : wptr_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = do_push ? PtrW'(1) : '0;
      count_d = do_push ? CntW'(1) : '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[waddr] <= data_i;
  end

endmodule

// File: rtl/serial_link_rx_queue_bridge.sv
// AXI write sink steering bursts into NumQueues FIFOs, drained and controlled via OBI.
module serial_link_rx_queue_bridge
  import serial_link_rx_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned Depth     = 8,
  parameter int unsigned NumQueues = 2,
  parameter int unsigned QSelLsb   = 4,
  parameter int unsigned IrqThr    = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic [DataWidth-1:0] w_data_i,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 reader_req_i,
  output logic                 reader_gnt_o,
  input  logic [AddrWidth-1:0] reader_addr_i,
  input  logic                 reader_we_i,
  input  logic [3:0]           reader_be_i,
  input  logic [31:0]          reader_wdata_i,
  output logic                 reader_rvalid_o,
  output logic [31:0]          reader_rdata_o,
  output logic [NumQueues-1:0] empty_o,
  output logic [NumQueues-1:0] full_o,
  output logic                 irq_o
);

  localparam int unsigned SelW = (NumQueues > 1) ? $clog2(NumQueues) : 1;
  localparam int unsigned QPad = 1 << SelW;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  wr_state_e            state_q, state_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [SelW-1:0]      sel_q, sel_d, sel_raw;
  logic                 err_q, err_d, sel_bad;
  logic                 aw_ready_q, b_valid_q;
  logic [1:0]           b_resp_q;
  logic                 w_beat;
  logic [QPad-1:0]      full_pad;

  logic                 rvalid_q;
  logic [31:0]          rdata_q, rdata_d;
  logic [NumQueues-1:0] uf_q, uf_d, irq_en_q, irq_en_d;
  logic [NumQueues-1:0] push_vec, pop_vec, flush_vec, thr_vec;
  logic                 irq_q;
  logic [4:0]           reg_idx;

  logic [DataWidth-1:0] head [NumQueues];
  logic [CntW-1:0]      cnt  [NumQueues];

  logic                 unused_bits;
  assign unused_bits = ^{reader_be_i, reader_addr_i, reader_wdata_i, aw_addr_i};

  assign aw_ready_o      = aw_ready_q;
  assign b_valid_o       = b_valid_q;
  assign b_resp_o        = b_resp_q;
  assign b_id_o          = id_q;
  assign reader_gnt_o    = reader_req_i;
  assign reader_rvalid_o = rvalid_q;
  assign reader_rdata_o  = rdata_q;
  assign irq_o           = irq_q;

  assign sel_raw   = aw_addr_i[QSelLsb +: SelW];
  assign sel_bad   = (NumQueues > 1) && (32'(sel_raw) >= NumQueues);
  assign full_pad  = QPad'(full_o);
  // Backpressure uses registered full so a same-cycle pop never lets a beat through.
  assign w_ready_o = (state_q == ST_DATA) && (err_q || !full_pad[sel_q]);
  assign w_beat    = w_valid_i && w_ready_o;
  assign reg_idx   = reader_addr_i[6:2];

  // Write burst FSM
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sel_d   = sel_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: if (aw_valid_i && aw_ready_q) begin
        state_d = ST_DATA;
        id_d    = aw_id_i;
        sel_d   = (NumQueues > 1) ? sel_raw : '0;
        err_d   = sel_bad;
      end
      ST_DATA: if (w_beat && w_last_i) state_d = ST_RESP;
      ST_RESP: if (b_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push_vec = '0;
    thr_vec  = '0;
    for (int q = 0; q < NumQueues; q++) begin
      push_vec[q] = w_beat && !err_q && (sel_q == SelW'(q));
      thr_vec[q]  = (cnt[q] >= CntW'(IrqThr));
    end
  end

  // OBI register access
  always_comb begin
    rdata_d   = rdata_q;
    pop_vec   = '0;
    flush_vec = '0;
    uf_d      = uf_q;
    irq_en_d  = irq_en_q;
    if (reader_req_i) begin
      rdata_d = '0;
      if (reader_we_i) begin
        if (reg_idx == OFF_FLUSH)  flush_vec = reader_wdata_i[NumQueues-1:0];
        if (reg_idx == OFF_IRQ_EN) irq_en_d  = reader_wdata_i[NumQueues-1:0];
      end else begin
        for (int q = 0; q < NumQueues; q++) begin
          if (reg_idx == OFF_QUEUE0 + 5'(q)) begin
            if (empty_o[q]) uf_d[q] = 1'b1;
            else begin
              pop_vec[q] = 1'b1;
              rdata_d    = head[q];
            end
          end
          if (reg_idx == OFF_FILL + 5'(q / 4)) rdata_d[8*(q%4) +: 8] = 8'(cnt[q]);
        end
        if (reg_idx == OFF_STATUS) rdata_d = {8'h00, 8'(uf_q), 8'(full_o), 8'(empty_o)};
        if (reg_idx == OFF_IRQ_EN) rdata_d = 32'(irq_en_q);
      end
    end
    uf_d = uf_d & ~flush_vec;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      aw_ready_q <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      uf_q       <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      aw_ready_q <= (state_d == ST_IDLE);
      b_valid_q  <= (state_d == ST_RESP);
      b_resp_q   <= ((state_d == ST_RESP) && err_d) ? RESP_SLVERR : RESP_OKAY;
      rvalid_q   <= reader_req_i;
      rdata_q    <= rdata_d;
      uf_q       <= uf_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= |(irq_en_q & thr_vec);
    end
  end

  for (genvar q = 0; q < NumQueues; q++) begin : g_queue
    serial_link_rx_fifo #(
      .Depth    (Depth),
      .DataWidth(DataWidth)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (push_vec[q]),
      .data_i (w_data_i),
      .pop_i  (pop_vec[q]),
      .flush_i(flush_vec[q]),
      .head_o (head[q]),
      .full_o (full_o[q]),
      .empty_o(empty_o[q]),
      .count_o(cnt[q])
    );
  end

endmodule

// File: tb/tb_serial_link_rx_queue_bridge.sv
// Directed bench for the receive queue bridge, instantiated with three queues.
module tb_serial_link_rx_queue_bridge;

  localparam int unsigned NQ = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          aw_valid_i, aw_ready_o;
  logic [31:0]   aw_addr_i;
  logic [3:0]    aw_id_i;
  logic          w_valid_i, w_ready_o, w_last_i;
  logic [31:0]   w_data_i;
  logic          b_valid_o, b_ready_i;
  logic [3:0]    b_id_o;
  logic [1:0]    b_resp_o;
  logic          reader_req_i, reader_gnt_o, reader_we_i, reader_rvalid_o;
  logic [31:0]   reader_addr_i, reader_wdata_i, reader_rdata_o;
  logic [3:0]    reader_be_i;
  logic [NQ-1:0] empty_o, full_o;
  logic          irq_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  serial_link_rx_queue_bridge #(.NumQueues(NQ)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .reader_req_i(reader_req_i), .reader_gnt_o(reader_gnt_o), .reader_addr_i(reader_addr_i),
    .reader_we_i(reader_we_i), .reader_be_i(reader_be_i), .reader_wdata_i(reader_wdata_i),
    .reader_rvalid_o(reader_rvalid_o), .reader_rdata_o(reader_rdata_o),
    .empty_o(empty_o), .full_o(full_o), .irq_o(irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic obi_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    reader_req_i  = 1'b1;
    reader_we_i   = 1'b0;
    reader_addr_i = addr;
    #1 chk({tag, " gnt"}, 32'(reader_gnt_o), 32'd1);
    tick();
    reader_req_i = 1'b0;
    chk({tag, " rvalid"}, 32'(reader_rvalid_o), 32'd1);
    chk(tag, reader_rdata_o, exp);
  endtask

  task automatic obi_write(input logic [31:0] addr, input logic [31:0] data);
    reader_req_i   = 1'b1;
    reader_we_i    = 1'b1;
    reader_addr_i  = addr;
    reader_wdata_i = data;
    tick();
    reader_req_i = 1'b0;
    reader_we_i  = 1'b0;
    chk("wr rdata zero", reader_rdata_o, 32'd0);
  endtask

  task automatic aw_only(input logic [31:0] addr, input logic [3:0] id);
    aw_valid_i = 1'b1;
    aw_addr_i  = addr;
    aw_id_i    = id;
    chk("aw_ready", 32'(aw_ready_o), 32'd1);
    tick();
    aw_valid_i = 1'b0;
  endtask

  task automatic b_finish(input logic [3:0] id, input logic [1:0] resp);
    for (int g = 0; g < 50 && !b_valid_o; g++) tick();
    chk("b_valid", 32'(b_valid_o), 32'd1);
    chk("b_resp", 32'(b_resp_o), 32'(resp));
    chk("b_id", 32'(b_id_o), 32'(id));
    b_ready_i = 1'b1;
    tick();
    b_ready_i = 1'b0;
    chk("b_valid drop", 32'(b_valid_o), 32'd0);
  endtask

  task automatic burst(input logic [31:0] addr, input logic [3:0] id, input int n,
                       input logic [31:0] base, input logic [1:0] resp);
    aw_only(addr, id);
    for (int i = 0; i < n; i++) begin
      w_valid_i = 1'b1;
      w_data_i  = base + 32'(i);
      w_last_i  = (i == n - 1);
      for (int g = 0; g < 50 && !w_ready_o; g++) tick();
      chk("w_ready wait", 32'(w_ready_o), 32'd1);
      tick();
    end
    w_valid_i = 1'b0;
    w_last_i  = 1'b0;
    b_finish(id, resp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    aw_valid_i = 1'b0; aw_addr_i = '0; aw_id_i = '0;
    w_valid_i = 1'b0; w_data_i = '0; w_last_i = 1'b0; b_ready_i = 1'b0;
    reader_req_i = 1'b0; reader_we_i = 1'b0; reader_addr_i = '0;
    reader_wdata_i = '0; reader_be_i = 4'hF;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst aw_ready", 32'(aw_ready_o), 32'd1);
    chk("rst w_ready", 32'(w_ready_o), 32'd0);
    chk("rst b_valid", 32'(b_valid_o), 32'd0);
    chk("rst rvalid", 32'(reader_rvalid_o), 32'd0);
    chk("rst empty", 32'(empty_o), 32'h7);
    chk("rst full", 32'(full_o), 32'h0);
    chk("rst irq", 32'(irq_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // 4-beat burst into queue 1, drained in order
    burst(32'h10, 4'h5, 4, 32'hA0, 2'b00);
    chk("t1 empty", 32'(empty_o), 32'h5);
    obi_read(32'h44, 32'h0000_0400, "t1 fill");
    for (int i = 0; i < 4; i++) obi_read(32'h04, 32'hA0 + 32'(i), "t1 pop");
    chk("t1 empty after", 32'(empty_o), 32'h7);

    // 10-beat burst into queue 0: stalls at full, resumes one beat per pop
    aw_only(32'h00, 4'h2);
    for (int i = 0; i < 8; i++) begin
      w_valid_i = 1'b1;
      w_data_i  = 32'hB0 + 32'(i);
      chk("t2 w_ready", 32'(w_ready_o), 32'd1);
      tick();
    end
    w_data_i = 32'hB8;
    chk("t2 full", 32'(full_o), 32'h1);
    chk("t2 stall", 32'(w_ready_o), 32'd0);
    tick();
    chk("t2 stall hold", 32'(w_ready_o), 32'd0);
    obi_read(32'h00, 32'hB0, "t2 pop0");
    chk("t2 resume", 32'(w_ready_o), 32'd1);
    tick();
    chk("t2 one beat only", 32'(w_ready_o), 32'd0);
    w_data_i = 32'hB9;
    w_last_i = 1'b1;
    obi_read(32'h00, 32'hB1, "t2 pop1");
    chk("t2 resume last", 32'(w_ready_o), 32'd1);
    tick();
    w_valid_i = 1'b0;
    w_last_i  = 1'b0;
    b_finish(4'h2, 2'b00);
    for (int i = 2; i < 10; i++) obi_read(32'h00, 32'hB0 + 32'(i), "t2 drain");
    chk("t2 empty", 32'(empty_o), 32'h7);

    // IRQ threshold of 6 on queue 0
    obi_write(32'h58, 32'h1);
    obi_read(32'h58, 32'h1, "t3 irq_en");
    burst(32'h00, 4'h1, 5, 32'hC0, 2'b00);
    tick();
    chk("t3 irq below thr", 32'(irq_o), 32'd0);
    burst(32'h00, 4'h1, 1, 32'hC5, 2'b00);
    chk("t3 irq at thr", 32'(irq_o), 32'd1);
    obi_read(32'h00, 32'hC0, "t3 pop");
    chk("t3 irq still reg", 32'(irq_o), 32'd1);
    tick();
    chk("t3 irq fall", 32'(irq_o), 32'd0);
    for (int i = 1; i < 6; i++) obi_read(32'h00, 32'hC0 + 32'(i), "t3 drain");
    obi_write(32'h58, 32'h0);

    // Underflow sticky bit and flush clear
    obi_read(32'h04, 32'h0, "t4 underflow rdata");
    obi_read(32'h40, 32'h0002_0007, "t4 status uf");
    obi_write(32'h54, 32'h2);
    obi_read(32'h40, 32'h0000_0007, "t4 status clr");

    // Out-of-range queue select: accepted, discarded, SLVERR
    burst(32'h30, 4'h7, 2, 32'hD0, 2'b10);
    chk("t5 empty", 32'(empty_o), 32'h7);
    obi_read(32'h44, 32'h0, "t5 fill");
    obi_write(32'h40, 32'hFFFF_FFFF);
    obi_read(32'h40, 32'h0000_0007, "t5 ro status");
    obi_read(32'h60, 32'h0, "t5 unmapped");

    // Flush concurrent with a push leaves only the pushed beat
    aw_only(32'h00, 4'h3);
    for (int i = 0; i < 2; i++) begin
      w_valid_i = 1'b1;
      w_data_i  = 32'hE0 + 32'(i);
      tick();
    end
    w_data_i = 32'hE2;
    w_last_i = 1'b1;
    reader_req_i = 1'b1; reader_we_i = 1'b1;
    reader_addr_i = 32'h54; reader_wdata_i = 32'h1;
    chk("t6 w_ready", 32'(w_ready_o), 32'd1);
    tick();
    reader_req_i = 1'b0; reader_we_i = 1'b0;
    w_valid_i = 1'b0; w_last_i = 1'b0;
    b_finish(4'h3, 2'b00);
    obi_read(32'h44, 32'h0000_0001, "t6 fill");
    obi_read(32'h00, 32'hE2, "t6 head");

    // Asynchronous reset in the middle of a burst
    obi_write(32'h58, 32'h2);
    aw_only(32'h10, 4'h9);
    for (int i = 0; i < 2; i++) begin
      w_valid_i = 1'b1;
      w_data_i  = 32'hF0 + 32'(i);
      tick();
    end
    chk("t7 pre empty", 32'(empty_o), 32'h5);
    rst_ni = 1'b0;
    #1;
    chk("t7 aw_ready", 32'(aw_ready_o), 32'd1);
    chk("t7 w_ready", 32'(w_ready_o), 32'd0);
    chk("t7 b_id", 32'(b_id_o), 32'd0);
    chk("t7 rdata", reader_rdata_o, 32'd0);
    chk("t7 empty", 32'(empty_o), 32'h7);
    w_valid_i = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();
    chk("t7 empty after", 32'(empty_o), 32'h7);
    obi_read(32'h58, 32'h0, "t7 irq_en");
    burst(32'h20, 4'h3, 1, 32'h55, 2'b00);
    obi_read(32'h08, 32'h55, "t7 q2 pop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_link_rx_queue_bridge.md
Name: serial_link_rx_queue_bridge

Overview:
Receive-side sink for the serial link's AXI master output. It replaces the single always-ready write FIFO with NumQueues independent FIFOs that apply real backpressure. AW/W beats are steered into a queue by address bits, and a proper B response is returned for every burst. A CPU drains the queues, reads status and controls flush/IRQ through an OBI slave port; everything runs in the serial-link clock domain.

Parameters:
DataWidth, 32, AXI W data width and OBI data width (must equal 32)
AddrWidth, 32, AXI AW / OBI address width
IdWidth, 4, AXI ID width
Depth, 8, entries per queue (power of two, >=2)
NumQueues, 2, number of receive queues (1..8)
QSelLsb, 4, LSB of the queue-select field in aw_addr_i
IrqThr, 6, fill level at which a queue raises its IRQ (1..Depth)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
aw_valid_i / aw_ready_o  in/out  1  AW handshake
aw_addr_i  in  AddrWidth  write address; [QSelLsb +: $clog2(NumQueues)] selects queue
aw_id_i  in  IdWidth  burst ID
w_valid_i / w_ready_o  in/out  1  W handshake
w_data_i  in  DataWidth  beat data
w_last_i  in  1  last beat of burst
b_valid_o / b_ready_i  out/in  1  B handshake
b_id_o  out  IdWidth  echoed aw ID
b_resp_o  out  2  00 OKAY, 10 SLVERR
reader_req_i / reader_gnt_o  in/out  1  OBI request/grant
reader_addr_i  in  AddrWidth  OBI address (bits [6:2] decoded)
reader_we_i  in  1  OBI write enable
reader_be_i  in  4  byte enables (ignored; full-word access)
reader_wdata_i  in  32  OBI write data
reader_rvalid_o  out  1  OBI response valid
reader_rdata_o  out  32  OBI read data
empty_o  out  NumQueues  per-queue empty
full_o  out  NumQueues  per-queue full
irq_o  out  1  level interrupt

Behaviour:
- Reset: aw_ready_o=1, w_ready_o=0, b_valid_o=0, b_id_o=0, b_resp_o=0, reader_rvalid_o=0, reader_rdata_o=0, all queues empty (empty_o all 1, full_o=0), irq_en=0, irq_o=0.
- Write FSM:
  - IDLE: aw_ready_o=1. On the AW handshake, latch the ID and queue select; sel>=NumQueues sets the err flag. Go to DATA.
  - DATA: aw_ready_o=0; w_ready_o = err | !full[sel], using registered full (no same-cycle pop fall-through).
  - Each accepted beat is pushed into queue sel, or discarded if err. On the beat with w_last_i, go to RESP.
  - RESP: b_valid_o=1, b_resp_o = err ? SLVERR : OKAY. Hold until b_ready_i, then return to IDLE.
  - One outstanding burst at a time. AR channel is not supported; the serial link's read path is tied off externally.
- OBI: reader_gnt_o = reader_req_i (combinational). reader_rvalid_o pulses exactly 1 cycle after grant; rdata is registered.
- OBI register map (word offsets):
  - 0x00+4q, read: pop queue q and return its head. If the queue is empty, return 0, no pop, and set sticky underflow bit q.
  - 0x40, read: {underflow[23:16], full[15:8], empty[7:0]}.
  - 0x44+... per queue q, read: fill count at 0x44 + 4*(q/4), byte lane q%4.
  - 0x54, write: flush mask; each set bit clears that queue and its underflow bit.
  - 0x58, read/write: irq_en[NumQueues-1:0].
  - Writes to read-only or unmapped offsets are accepted and ignored; reads of unmapped offsets return 0.
  - rdata is written as 0 for write accesses.
- Queue arithmetic: wptr/rptr are $clog2(Depth) bits and wrap modulo Depth; count is $clog2(Depth)+1 bits.
- Simultaneous push and pop on the same queue: both happen, count unchanged. Pop on an empty queue is never satisfied by a same-cycle push.
- Flush with a concurrent push on the same queue: the queue ends holding exactly the pushed beat (count=1).
- irq_o = |(irq_en & (count_q >= IrqThr)), registered. It deasserts the cycle after the count drops below threshold.

Decomposition:
- Package serial_link_rx_pkg: register offsets, RESP_OKAY/RESP_SLVERR, write FSM state enum.
- Sub-module serial_link_rx_fifo (single queue): push/pop/flush inputs; full/empty/count outputs; instantiated NumQueues times.

Test Plan:
- 4-beat burst to aw_addr=0x10 (q1), data 0xA0..0xA3 -> b_resp=OKAY, b_id echoed; empty_o=2'b01; four reads of 0x04 return 0xA0..0xA3 in order; q1 empty afterwards.
- 10-beat burst to q0 with no reads -> w_ready_o drops after beat 8 (full_o[0]=1). Read 0x00 once -> exactly one more beat is accepted the following cycle; no data lost or reordered.
- irq_en=1, push 6 beats into q0 -> irq_o rises the cycle after the 6th push; one pop -> irq_o falls.
- Read 0x04 with q1 empty -> rdata=0; status bit 17 set; a flush of q1 (write 0x2 to 0x54) clears it.
- NumQueues=3, AW addr=0x30 (sel=3) with a 2-beat burst -> both beats accepted and discarded, b_resp=SLVERR; all queues unchanged.
- rst_ni asserted while in DATA with 2 beats queued -> all outputs return to reset values immediately; queues are empty after release.
